// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: FSM encodings, requester ids and saturating counter helper shared by the cache arbiter
package cache_arb_pkg;
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ISSUE = 2'b01;
  localparam logic [1:0] WAIT  = 2'b10;
  localparam logic REQ_D = 1'b0;
  localparam logic REQ_I = 1'b1;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/cache_arbiter_rr_arb2.sv
// rr_arb2: two-way grant, alternating on the last-served pointer or fixed priority to requester 0
module rr_arb2 import cache_arb_pkg::*; (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       mode,
  output logic [1:0] grant
);
  assign grant = (&valid) ? ((mode || last == REQ_I) ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises a data and an instruction requester onto one cache port, one access in flight
module cache_arbiter import cache_arb_pkg::*; #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_din,
  output logic              r0_ready,
  output logic              r0_resp_valid,
  output logic [DATA_W-1:0] r0_dout,
  output logic              r0_hit,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_ready,
  output logic              r1_resp_valid,
  output logic [DATA_W-1:0] r1_dout,
  output logic              r1_hit,
  output logic              c_input_valid,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_mem_read,
  output logic              c_mem_write,
  output logic [DATA_W-1:0] c_din,
  input  logic              c_ready,
  input  logic              c_output_valid,
  input  logic [DATA_W-1:0] c_dout,
  input  logic              c_is_hit,
  output logic [31:0]       hit_cnt0,
  output logic [31:0]       miss_cnt0,
  output logic [31:0]       hit_cnt1,
  output logic [31:0]       miss_cnt1
);
  logic [1:0] state, grant;
  logic last, cur, h_read, h_write, idle, acc0, acc1, done;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_din;
  logic [31:0] hc0, mc0, hc1, mc1;
  rr_arb2 u_arb (
    .valid({r1_valid, r0_valid}),
    .last (last),
    .mode (PRIO_MODE != 0),
    .grant(grant)
  );
  assign idle          = reset && state == IDLE;
  assign r0_ready      = idle && grant[0];
  assign r1_ready      = idle && grant[1];
  assign acc0          = r0_valid && r0_ready;
  assign acc1          = r1_valid && r1_ready;
  assign done          = state == WAIT && c_output_valid;
  assign c_input_valid = reset && state == ISSUE;
  assign c_addr        = h_addr;
  assign c_mem_read    = h_read;
  assign c_mem_write   = h_write;
  assign c_din         = h_din;
  assign hit_cnt0      = hc0;
  assign miss_cnt0     = mc0;
  assign hit_cnt1      = hc1;
  assign miss_cnt1     = mc1;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      last          <= REQ_I;
      cur           <= REQ_D;
      h_addr        <= '0;
      h_read        <= 1'b0;
      h_write       <= 1'b0;
      h_din         <= '0;
      r0_resp_valid <= 1'b0;
      r1_resp_valid <= 1'b0;
      r0_dout       <= '0;
      r1_dout       <= '0;
      r0_hit        <= 1'b0;
      r1_hit        <= 1'b0;
      hc0           <= '0;
      mc0           <= '0;
      hc1           <= '0;
      mc1           <= '0;
    end else begin
      r0_resp_valid <= done && cur == REQ_D;
      r1_resp_valid <= done && cur == REQ_I;
      if (acc0 || acc1) begin
        state   <= ISSUE;
        cur     <= acc1;
        last    <= acc1;
        h_addr  <= acc1 ? r1_addr : r0_addr;
        h_read  <= acc1 || (r0_read && !r0_write);
        h_write <= acc0 && r0_write;
        h_din   <= acc1 ? '0 : r0_din;
      end else if (state == ISSUE && c_ready) begin
        state <= WAIT;
      end else if (done) begin
        state <= IDLE;
        if (cur == REQ_D) begin
          r0_dout <= c_dout;
          r0_hit  <= c_is_hit;
          hc0     <= c_is_hit ? sat_inc(hc0) : hc0;
          mc0     <= c_is_hit ? mc0 : sat_inc(mc0);
        end else begin
          r1_dout <= c_dout;
          r1_hit  <= c_is_hit;
          hc1     <= c_is_hit ? sat_inc(hc1) : hc1;
          mc1     <= c_is_hit ? mc1 : sat_inc(mc1);
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  typedef struct {
    logic          id;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [DW-1:0] din;
  } txn_t;
  logic clk = 0, reset = 0;
  logic r0_valid = 0, r0_read = 0, r0_write = 0, r1_valid = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_din = '0;
  logic c_ready = 0, c_output_valid = 0, c_is_hit = 0;
  logic [DW-1:0] c_dout = '0;
  logic r0_ready, r0_resp_valid, r0_hit, r1_ready, r1_resp_valid, r1_hit;
  logic [DW-1:0] r0_dout, r1_dout, c_din;
  logic c_input_valid, c_mem_read, c_mem_write;
  logic [AW-1:0] c_addr;
  logic [31:0] hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1;
  logic f_r0_ready, f_r0_resp_valid, f_r0_hit, f_r1_ready, f_r1_resp_valid, f_r1_hit;
  logic [DW-1:0] f_r0_dout, f_r1_dout, f_c_din;
  logic f_c_input_valid, f_c_mem_read, f_c_mem_write;
  logic [AW-1:0] f_c_addr;
  logic [31:0] f_hit_cnt0, f_miss_cnt0, f_hit_cnt1, f_miss_cnt1;
  int checks = 0, errors = 0;
  int rdy_delay = 0, lat = 0, rcnt = 0, wcnt = 0;
  bit in_flight = 0, ov_force = 0, rand_rsp = 0, rand_timing = 0;
  logic [DW-1:0] rsp_data = '0;
  logic rsp_hit = 0;
  logic [DW:0] rsp_q[$];

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_read(r0_read), .r0_write(r0_write), .r0_din(r0_din),
    .r0_ready(r0_ready), .r0_resp_valid(r0_resp_valid), .r0_dout(r0_dout), .r0_hit(r0_hit),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready), .r1_resp_valid(r1_resp_valid),
    .r1_dout(r1_dout), .r1_hit(r1_hit),
    .c_input_valid(c_input_valid), .c_addr(c_addr), .c_mem_read(c_mem_read), .c_mem_write(c_mem_write),
    .c_din(c_din), .c_ready(c_ready), .c_output_valid(c_output_valid), .c_dout(c_dout), .c_is_hit(c_is_hit),
    .hit_cnt0(hit_cnt0), .miss_cnt0(miss_cnt0), .hit_cnt1(hit_cnt1), .miss_cnt1(miss_cnt1)
  );

  cache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_f (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_read(r0_read), .r0_write(r0_write), .r0_din(r0_din),
    .r0_ready(f_r0_ready), .r0_resp_valid(f_r0_resp_valid), .r0_dout(f_r0_dout), .r0_hit(f_r0_hit),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(f_r1_ready), .r1_resp_valid(f_r1_resp_valid),
    .r1_dout(f_r1_dout), .r1_hit(f_r1_hit),
    .c_input_valid(f_c_input_valid), .c_addr(f_c_addr), .c_mem_read(f_c_mem_read),
    .c_mem_write(f_c_mem_write), .c_din(f_c_din), .c_ready(c_ready), .c_output_valid(c_output_valid),
    .c_dout(c_dout), .c_is_hit(c_is_hit),
    .hit_cnt0(f_hit_cnt0), .miss_cnt0(f_miss_cnt0), .hit_cnt1(f_hit_cnt1), .miss_cnt1(f_miss_cnt1)
  );

  // Cache model: accepts after rdy_delay stall cycles, answers lat cycles into WAIT, logs each answer
  always @(negedge clk) begin
    c_ready = 0;
    c_output_valid = ov_force;
    if (!reset) begin
      in_flight = 0;
      rcnt = 0;
    end else if (in_flight) begin
      if (wcnt == lat) begin
        if (rand_rsp) begin
          rsp_data = $urandom;
          rsp_hit = 1'($urandom_range(0, 1));
        end
        if (rand_timing) begin
          rdy_delay = $urandom_range(0, 3);
          lat = $urandom_range(0, 4);
        end
        c_output_valid = 1;
        c_dout = rsp_data;
        c_is_hit = rsp_hit;
        rsp_q.push_back({rsp_hit, rsp_data});
        in_flight = 0;
      end else wcnt++;
    end else if (c_input_valid) begin
      if (rcnt >= rdy_delay) begin
        c_ready = 1;
        in_flight = 1;
        wcnt = 0;
        rcnt = 0;
      end else rcnt++;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    r0_valid = 0;
    r1_valid = 0;
    ov_force = 0;
    rand_rsp = 0;
    rand_timing = 0;
    rdy_delay = 0;
    lat = 0;
    repeat (2) cyc();
    rsp_q.delete();
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({r0_resp_valid, r1_resp_valid, r0_hit, r1_hit, c_input_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000", {r0_resp_valid, r1_resp_valid, r0_hit, r1_hit, c_input_valid});
    end
    checks++;
    if ({r0_dout, r1_dout} !== '0) begin
      errors++;
      $display("FAIL reset_dout got %h exp 0", {r0_dout, r1_dout});
    end
    checks++;
    if ({hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1} !== '0) begin
      errors++;
      $display("FAIL reset_counters got %h exp 0", {hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1});
    end
    checks++;
    if ({c_addr, c_din, c_mem_read, c_mem_write} !== '0) begin
      errors++;
      $display("FAIL reset_holding got %h exp 0", {c_addr, c_din, c_mem_read, c_mem_write});
    end
  endtask

  task automatic test_single_hit();
    do_reset();
    rsp_data = 32'hDEAD_BEEF;
    rsp_hit = 1;
    r1_valid = 1;
    r1_addr = 32'h0000_0100;
    #1;
    checks++;
    if ({r1_ready, r0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready got %b exp 10", {r1_ready, r0_ready});
    end
    cyc();
    r1_valid = 0;
    checks++;
    if ({c_input_valid, c_addr, c_mem_read, c_mem_write} !== {1'b1, 32'h100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_issue got %h exp %h", {c_input_valid, c_addr, c_mem_read, c_mem_write},
               {1'b1, 32'h100, 1'b1, 1'b0});
    end
    cyc();
    checks++;
    if (r1_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_resp got %b exp 0", r1_resp_valid);
    end
    cyc();
    checks++;
    if ({r1_resp_valid, r1_dout, r1_hit, hit_cnt1, miss_cnt1} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL single_resp got %h exp %h", {r1_resp_valid, r1_dout, r1_hit, hit_cnt1, miss_cnt1},
               {1'b1, 32'hDEAD_BEEF, 1'b1, 32'd1, 32'd0});
    end
    cyc();
    checks++;
    if (r1_resp_valid !== 1'b0 || r1_dout !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_pulse_hold got %b/%h exp 0/deadbeef", r1_resp_valid, r1_dout);
    end
  endtask

  task automatic test_rr_and_fixed();
    int n = 0;
    do_reset();
    r0_valid = 1;
    r1_valid = 1;
    r0_read = 1;
    r0_write = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      #1;
      if (r0_ready || r1_ready) begin
        checks++;
        if ({r1_ready, r0_ready} !== ((n % 2) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_grant%0d got %b exp %b", n, {r1_ready, r0_ready}, (n % 2) ? 2'b10 : 2'b01);
        end
        checks++;
        if ({f_r1_ready, f_r0_ready} !== 2'b01) begin
          errors++;
          $display("FAIL fixed_grant%0d got %b exp 01", n, {f_r1_ready, f_r0_ready});
        end
        n++;
      end
      cyc();
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL rr_accepts got %0d exp 6", n);
    end
    r0_valid = 0;
    r1_valid = 0;
    repeat (4) cyc();
  endtask

  task automatic test_write_stall();
    int ivc = 0, pulses = 0;
    bit seen = 0;
    do_reset();
    rdy_delay = 4;
    lat = 20;
    rsp_data = 32'hCAFE_0000;
    rsp_hit = 0;
    r0_valid = 1;
    r0_read = 0;
    r0_write = 1;
    r0_addr = 32'h40;
    r0_din = 32'h1234_5678;
    #1;
    checks++;
    if (r0_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready got %b exp 1", r0_ready);
    end
    for (int c = 0; c < 40; c++) begin
      cyc();
      r0_valid = 0;
      r0_addr = $urandom;
      r0_din = $urandom;
      ivc += int'(c_input_valid);
      if (r0_resp_valid) pulses++;
      if (!seen) begin
        checks++;
        if ({c_addr, c_din, c_mem_write, c_mem_read} !== {32'h40, 32'h1234_5678, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL stall_stable c%0d got %h exp %h", c, {c_addr, c_din, c_mem_write, c_mem_read},
                   {32'h40, 32'h1234_5678, 1'b1, 1'b0});
        end
      end
      seen |= r0_resp_valid;
    end
    checks++;
    if (ivc != 5 || pulses != 1) begin
      errors++;
      $display("FAIL stall_counts got iv=%0d pulses=%0d exp iv=5 pulses=1", ivc, pulses);
    end
    checks++;
    if ({miss_cnt0, hit_cnt0, r0_hit, r0_dout} !== {32'd1, 32'd0, 1'b0, 32'hCAFE_0000}) begin
      errors++;
      $display("FAIL stall_result got %h exp %h", {miss_cnt0, hit_cnt0, r0_hit, r0_dout},
               {32'd1, 32'd0, 1'b0, 32'hCAFE_0000});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 10;
    rsp_hit = 1;
    rsp_data = 32'h7777_0001;
    r1_valid = 1;
    r1_addr = 32'h200;
    cyc();
    r1_valid = 0;
    repeat (3) cyc();
    reset = 0;
    r1_valid = 1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++;
      if ({c_input_valid, r0_ready, r1_ready, r0_resp_valid, r1_resp_valid} !== 5'b0) begin
        errors++;
        $display("FAIL midreset_out c%0d got %b exp 00000", c,
                 {c_input_valid, r0_ready, r1_ready, r0_resp_valid, r1_resp_valid});
      end
    end
    checks++;
    if ({hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1} !== '0) begin
      errors++;
      $display("FAIL midreset_counters got %h exp 0", {hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1});
    end
    rsp_q.delete();
    lat = 0;
    reset = 1;
    #1;
    checks++;
    if (r1_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_accept got %b exp 1", r1_ready);
    end
    cyc();
    r1_valid = 0;
    cyc();
    cyc();
    checks++;
    if ({r1_resp_valid, r1_dout, hit_cnt1} !== {1'b1, 32'h7777_0001, 32'd1}) begin
      errors++;
      $display("FAIL midreset_resp got %h exp %h", {r1_resp_valid, r1_dout, hit_cnt1}, {1'b1, 32'h7777_0001, 32'd1});
    end
  endtask

  task automatic test_rw_and_stray_valid();
    int pulses = 0;
    do_reset();
    ov_force = 1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if ({r0_resp_valid, r1_resp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL stray_idle c%0d got %b exp 00", c, {r0_resp_valid, r1_resp_valid});
      end
    end
    rdy_delay = 3;
    lat = 0;
    rsp_data = 32'h0BAD_F00D;
    rsp_hit = 1;
    r0_valid = 1;
    r0_read = 1;
    r0_write = 1;
    r0_addr = 32'h80;
    r0_din = 32'h55AA;
    for (int c = 0; c < 12; c++) begin
      cyc();
      r0_valid = 0;
      if (r0_resp_valid || r1_resp_valid) pulses++;
      if (c_input_valid) begin
        checks++;
        if ({c_mem_write, c_mem_read, c_din} !== {1'b1, 1'b0, 32'h55AA}) begin
          errors++;
          $display("FAIL rw_as_write got %h exp %h", {c_mem_write, c_mem_read, c_din}, {1'b1, 1'b0, 32'h55AA});
        end
      end
    end
    checks++;
    if (pulses != 1 || r0_dout !== 32'h0BAD_F00D || hit_cnt0 !== 32'd1) begin
      errors++;
      $display("FAIL rw_resp got pulses=%0d dout=%h hits=%0d exp 1/0badf00d/1", pulses, r0_dout, hit_cnt0);
    end
    ov_force = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    rsp_hit = 1;
    force dut.hc0 = 32'hFFFF_FFFE;
    cyc();
    release dut.hc0;
    for (int k = 0; k < 3; k++) begin
      r0_valid = 1;
      r0_read = 1;
      r0_write = 0;
      cyc();
      r0_valid = 0;
      cyc();
      cyc();
      checks++;
      if ({r0_resp_valid, hit_cnt0} !== {1'b1, 32'hFFFF_FFFF}) begin
        errors++;
        $display("FAIL saturate%0d got %h exp 1ffffffff", k, {r0_resp_valid, hit_cnt0});
      end
    end
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0, busy = 0;
    logic last = 1;
    logic [1:0] eg;
    logic [DW:0] rsp;
    txn_t cur;
    int hc[2] = '{0, 0};
    int mc[2] = '{0, 0};
    do_reset();
    rand_rsp = 1;
    rand_timing = 1;
    for (int c = 0; c < 400; c++) begin
      if (r0_resp_valid || r1_resp_valid) begin
        checks++;
        if (!busy || rsp_q.size() == 0 || {r1_resp_valid, r0_resp_valid} !== (cur.id ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rand_resp_who c%0d got %b exp busy id %0d", c, {r1_resp_valid, r0_resp_valid}, cur.id);
        end else begin
          rsp = rsp_q.pop_front();
          if (rsp[DW]) hc[cur.id]++;
          else mc[cur.id]++;
          checks++;
          if ((cur.id ? {r1_hit, r1_dout} : {r0_hit, r0_dout}) !== rsp) begin
            errors++;
            $display("FAIL rand_resp_data c%0d got %h exp %h", c, cur.id ? {r1_hit, r1_dout} : {r0_hit, r0_dout}, rsp);
          end
          checks++;
          if ({hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1} !== {32'(hc[0]), 32'(mc[0]), 32'(hc[1]), 32'(mc[1])}) begin
            errors++;
            $display("FAIL rand_counters c%0d got %h exp %h", c, {hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1},
                     {32'(hc[0]), 32'(mc[0]), 32'(hc[1]), 32'(mc[1])});
          end
        end
        busy = 0;
      end
      if (busy && c_input_valid) begin
        checks++;
        if (c_addr !== cur.addr || c_mem_read !== cur.rd || c_mem_write !== cur.wr || (cur.wr && c_din !== cur.din)) begin
          errors++;
          $display("FAIL rand_issue c%0d got %h/%b%b/%h exp %h/%b%b/%h", c, c_addr, c_mem_read, c_mem_write, c_din,
                   cur.addr, cur.rd, cur.wr, cur.din);
        end
      end
      if (!p0 && c < 340 && $urandom_range(0, 1) == 1) begin
        p0 = 1;
        r0_addr = $urandom;
        {r0_read, r0_write} = 2'($urandom_range(1, 3));
        r0_din = $urandom;
      end
      if (!p1 && c < 340 && $urandom_range(0, 2) == 0) begin
        p1 = 1;
        r1_addr = $urandom;
      end
      r0_valid = p0;
      r1_valid = p1;
      #1;
      eg = busy ? 2'b00 : (p0 && p1) ? (last ? 2'b01 : 2'b10) : {p1, p0};
      checks++;
      if ({r1_ready, r0_ready} !== eg) begin
        errors++;
        $display("FAIL rand_grant c%0d got %b exp %b", c, {r1_ready, r0_ready}, eg);
      end
      if ((r0_valid && r0_ready) || (r1_valid && r1_ready)) begin
        cur.id = r1_ready;
        cur.addr = r1_ready ? r1_addr : r0_addr;
        cur.rd = r1_ready || (r0_read && !r0_write);
        cur.wr = !r1_ready && r0_write;
        cur.din = r0_din;
        busy = 1;
        last = cur.id;
        if (r1_ready) p1 = 0;
        else p0 = 0;
      end
      cyc();
    end
    checks++;
    if (busy || p0 || p1) begin
      errors++;
      $display("FAIL rand_drain got busy=%0d p0=%0d p1=%0d exp 0/0/0", busy, p0, p1);
    end
    r0_valid = 0;
    r1_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_hit();
    test_rr_and_fixed();
    test_write_stall();
    test_reset_mid();
    test_rw_and_stray_valid();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
